// File: rtl/fetch_sequencer_if.sv
// Handshake and control bundle between the fetch sequencer and its harness/decoder/fetch stage.
// The master modport is the sequencer side; the slave modport is the harness/decoder/fetch side.
interface fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             IsBranch;
    logic             IsHalt;
    logic [2:0]       Offset;
    logic             CondFlag;
    logic             Init;
    logic             Halt;
    logic             Branch;
    logic [2:0]       Target;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;
    logic [7:0]       BranchCount;

    modport master (
        input  Start, IsBranch, IsHalt, Offset, CondFlag,
        output Init, Halt, Branch, Target, Done, Timeout, CycleCount, BranchCount
    );

    modport slave (
        output Start, IsBranch, IsHalt, Offset, CondFlag,
        input  Init, Halt, Branch, Target, Done, Timeout, CycleCount, BranchCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Run-state FSM driving Init/Halt/Branch/Target for the fetch stage, with cycle and
// taken-branch statistics and a watchdog that halts runaway programs.
module fetch_sequencer #(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_CYCLES  = 4000,
    parameter int CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [15:0]      INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_init_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [7:0]       r_branch_cnt;
    logic             r_timeout;
    logic             w_wdog;
    logic             w_init;
    logic             w_halt;
    logic             w_branch;
    logic [2:0]       w_target;

    assign w_wdog = (r_state == S_RUN) && (r_cycle_cnt == WDOG_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // The watchdog cycle behaves like a halt instruction: PC frozen, no branch, no count.
    always_comb begin
        w_next   = r_state;
        w_init   = 1'b0;
        w_halt   = 1'b1;
        w_branch = 1'b0;
        w_target = 3'd0;
        case (r_state)
            S_IDLE: begin
                w_init = 1'b1;
                if (bus.Start) w_next = S_INIT;
            end
            S_INIT: begin
                w_init = 1'b1;
                w_halt = 1'b0;
                if (r_init_cnt == INIT_LAST) w_next = S_RUN;
            end
            S_RUN: begin
                w_target = bus.Offset;
                if (w_wdog) begin
                    w_next = S_HALTED;
                end else begin
                    w_halt   = bus.IsHalt;
                    w_branch = bus.IsBranch & bus.CondFlag & ~bus.IsHalt;
                    if (bus.IsHalt) w_next = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!bus.Start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_init_cnt   <= '0;
            r_cycle_cnt  <= '0;
            r_branch_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_init_cnt   <= '0;
                        r_cycle_cnt  <= '0;
                        r_branch_cnt <= '0;
                        r_timeout    <= 1'b0;
                    end
                end
                S_INIT: r_init_cnt <= r_init_cnt + 16'd1;
                S_RUN: begin
                    if (w_wdog) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                        if (w_branch && (r_branch_cnt != 8'hFF))
                            r_branch_cnt <= r_branch_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Init        = w_init;
    assign bus.Halt        = w_halt;
    assign bus.Branch      = w_branch;
    assign bus.Target      = w_target;
    assign bus.Done        = (r_state == S_HALTED);
    assign bus.Timeout     = r_timeout;
    assign bus.CycleCount  = r_cycle_cnt;
    assign bus.BranchCount = r_branch_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of per-cycle vectors, then hand-written
// watchdog self-loop and reset-during-run sequences.
module tb_fetch_sequencer;
    logic CLK;
    logic RST_n;
    int   checks;
    int   errors;

    fetch_sequencer_if #(.CNT_W(16)) bus ();

    fetch_sequencer #(
        .INIT_CYCLES(2),
        .MAX_CYCLES (16),
        .CNT_W      (16)
    ) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       isbr;
        logic       ishalt;
        logic [2:0] off;
        logic       cond;
        logic       init;
        logic       halt;
        logic       br;
        logic [2:0] tgt;
        logic       done;
        logic       to;
        int         cc;
        int         bc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic start, input logic isbr, input logic ishalt,
                       input logic [2:0] off, input logic cond,
                       input logic init, input logic halt, input logic br, input logic [2:0] tgt,
                       input logic done, input logic to, input int cc, input int bc);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.isbr = isbr; v.ishalt = ishalt;
        v.off = off; v.cond = cond;
        v.init = init; v.halt = halt; v.br = br; v.tgt = tgt;
        v.done = done; v.to = to; v.cc = cc; v.bc = bc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic start, input logic isbr,
                         input logic ishalt, input logic [2:0] off, input logic cond);
        RST_n        = rst_n;
        bus.Start    = start;
        bus.IsBranch = isbr;
        bus.IsHalt   = ishalt;
        bus.Offset   = off;
        bus.CondFlag = cond;
    endtask

    task automatic chk_all(input string tag, input logic init, input logic halt, input logic br,
                           input logic [2:0] tgt, input logic done, input logic to,
                           input int cc, input int bc);
        chk({tag, ".Init"},        32'(bus.Init),        32'(init));
        chk({tag, ".Halt"},        32'(bus.Halt),        32'(halt));
        chk({tag, ".Branch"},      32'(bus.Branch),      32'(br));
        chk({tag, ".Target"},      32'(bus.Target),      32'(tgt));
        chk({tag, ".Done"},        32'(bus.Done),        32'(done));
        chk({tag, ".Timeout"},     32'(bus.Timeout),     32'(to));
        chk({tag, ".CycleCount"},  32'(bus.CycleCount),  32'(cc));
        chk({tag, ".BranchCount"}, 32'(bus.BranchCount), 32'(bc));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // reset held, then start; Start drop inside INIT is ignored
        add(0,1,0,0,3'd0,0, 1,1,0,3'd0,0,0, 0,0);
        add(0,1,0,0,3'd0,0, 1,1,0,3'd0,0,0, 0,0);
        add(1,1,0,0,3'd0,0, 1,1,0,3'd0,0,0, 0,0);
        add(1,0,0,0,3'd0,0, 1,0,0,3'd0,0,0, 0,0);
        add(1,1,0,0,3'd0,0, 1,0,0,3'd0,0,0, 0,0);
        // RUN: taken branch with Offset 6, then untaken (CondFlag=0)
        add(1,1,1,0,3'd6,1, 0,0,1,3'd6,0,0, 0,0);
        add(1,1,1,0,3'd6,0, 0,0,0,3'd6,0,0, 1,1);
        add(1,1,0,0,3'd0,0, 0,0,0,3'd0,0,0, 2,1);
        for (int k = 3; k <= 8; k++)
            add(1,1,0,0,3'd0,0, 0,0,0,3'd0,0,0, k,1);
        // 10th RUN cycle: halt together with a taken branch, halt wins
        add(1,1,1,1,3'd2,1, 0,1,0,3'd2,0,0, 9,1);
        add(1,1,0,0,3'd0,0, 0,1,0,3'd0,1,0, 10,1);
        add(1,0,0,0,3'd0,0, 0,1,0,3'd0,1,0, 10,1);
        add(1,0,0,0,3'd0,0, 1,1,0,3'd0,0,0, 10,1);

        @(negedge CLK);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].isbr, tbl[i].ishalt, tbl[i].off, tbl[i].cond);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].init, tbl[i].halt, tbl[i].br, tbl[i].tgt,
                    tbl[i].done, tbl[i].to, tbl[i].cc, tbl[i].bc);
            @(negedge CLK);
        end

        // Self-loop (Target 0) ended only by the watchdog
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        #1 chk("loop.idle.Init", 32'(bus.Init), 32'd1);
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("loop.init%0d.Init", k), 32'(bus.Init), 32'd1);
            chk($sformatf("loop.init%0d.Halt", k), 32'(bus.Halt), 32'd0);
            @(negedge CLK);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            #1;
            chk($sformatf("loop.run%0d.Branch", k), 32'(bus.Branch), 32'd1);
            chk($sformatf("loop.run%0d.Halt", k), 32'(bus.Halt), 32'd0);
            chk($sformatf("loop.run%0d.CycleCount", k), 32'(bus.CycleCount), 32'(k));
            @(negedge CLK);
        end
        #1 chk_all("wdog", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 15, 15);
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        #1 chk_all("wdog.halted", 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 15, 15);
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        #1 chk("wdog.hold.Done", 32'(bus.Done), 32'd1);
        @(negedge CLK);
        #1 chk_all("wdog.idle", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 15, 15);
        @(negedge CLK);

        // Reset during RUN aborts without a Done pulse
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (3) @(negedge CLK);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
        repeat (3) @(negedge CLK);
        #1 chk_all("abort.run", 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3, 3);
        RST_n = 1'b0;
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        #1 chk_all("abort.rst", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("abort.after%0d.Done", k), 32'(bus.Done), 32'd0);
            chk($sformatf("abort.after%0d.Init", k), 32'(bus.Init), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
